// File: rtl/rbf_distance.sv
// rtl/rbf_distance.sv - squared-distance accumulator scaled by -gamma for the RBF exponential
module rbf_distance #(
    parameter int FEATURE_COUNT = 8,
    parameter int FEATURE_WIDTH = 16,
    parameter int FEATURE_FRAC  = 8,
    parameter int ACC_WIDTH     = 40,
    parameter int GAMMA_WIDTH   = 16,
    parameter int GAMMA_FRAC    = 12,
    parameter int X_INT         = 8,
    parameter int X_FRAC        = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FEATURE_WIDTH-1:0]       feature_a,
    input  logic [FEATURE_WIDTH-1:0]       feature_b,
    input  logic [GAMMA_WIDTH-1:0]         gamma,
    output logic [X_INT+X_FRAC-1:0]        x,
    output logic                           data_valid
);

    localparam int XW     = X_INT + X_FRAC;
    localparam int DW     = FEATURE_WIDTH + 1;
    localparam int SQ_W   = 2 * FEATURE_WIDTH + 1;
    localparam int SUM_W  = ((ACC_WIDTH > SQ_W) ? ACC_WIDTH : SQ_W) + 1;
    localparam int PROD_W = ACC_WIDTH + GAMMA_WIDTH;
    localparam int SHIFT  = 2 * FEATURE_FRAC + GAMMA_FRAC - X_FRAC;
    localparam int CNT_W  = (FEATURE_COUNT > 1) ? $clog2(FEATURE_COUNT) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FEATURE_COUNT - 1);
    localparam logic [PROD_W-1:0] X_LIM    = PROD_W'(1) << (XW - 1);
    localparam logic [XW-1:0]     X_SAT    = {1'b1, {(XW-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, DRAIN, SCALE, EMIT} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DW-1:0]       r_diff;
    logic                r_diff_valid;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [PROD_W-1:0]   r_prod;
    logic [XW-1:0]       r_x;
    logic                r_data_valid;

    logic                w_xfer;
    logic [DW-1:0]       w_diff;
    logic [DW-1:0]       w_abs;
    logic [SQ_W-1:0]     w_sq;
    logic [SUM_W-1:0]    w_sum;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic [PROD_W-1:0]   w_mag;
    logic [XW-1:0]       w_x;

    assign in_ready   = (r_state == ACCUM);
    assign w_xfer     = in_valid & in_ready;
    assign x          = r_x;
    assign data_valid = r_data_valid;

    // Exact difference: sign-extend both features by one bit before subtracting.
    assign w_diff = {feature_a[FEATURE_WIDTH-1], feature_a} - {feature_b[FEATURE_WIDTH-1], feature_b};

    // Square via magnitude so the multiplier stays unsigned.
    assign w_abs = r_diff[DW-1] ? (~r_diff + DW'(1)) : r_diff;
    assign w_sq  = SQ_W'(w_abs) * SQ_W'(w_abs);

    // Saturating accumulate: any carry above ACC_WIDTH pins the accumulator at all-ones.
    assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_sq);
    assign w_acc_next = (|w_sum[SUM_W-1:ACC_WIDTH]) ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];

    // Drop the surplus fraction bits, then negate with clamping at the most negative x.
    assign w_mag = r_prod >> SHIFT;
    assign w_x   = (w_mag >= X_LIM) ? X_SAT : (XW'(0) - w_mag[XW-1:0]);

    // Vector sequencing, accumulation, scaling and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ACCUM;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_diff_valid <= 1'b0;
            r_acc        <= '0;
            r_prod       <= '0;
            r_x          <= '0;
            r_data_valid <= 1'b0;
        end else if (clear) begin
            r_state      <= ACCUM;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_diff_valid <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_diff_valid <= w_xfer;
            if (w_xfer) begin
                r_diff <= w_diff;
            end
            if (r_state == EMIT) begin
                r_acc <= '0;
            end else if (r_diff_valid) begin
                r_acc <= w_acc_next;
            end
            case (r_state)
                ACCUM: begin
                    if (w_xfer) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    r_state <= SCALE;
                end
                SCALE: begin
                    r_prod  <= PROD_W'(r_acc) * PROD_W'(gamma);
                    r_state <= EMIT;
                end
                EMIT: begin
                    r_x          <= w_x;
                    r_data_valid <= 1'b1;
                    r_state      <= ACCUM;
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: doc/rbf_distance.md
# rbf_distance

Producer side of the RBF kernel exponential. Streams one feature pair (support-vector feature, sample feature) per accepted cycle and accumulates the squared Euclidean distance over FEATURE_COUNT pairs. Scales the distance by -gamma and saturates it into the exponential input format. Drives x/data_valid so they connect directly to the exponential unit's x/data_valid inputs.

## Interface
- FEATURE_COUNT, 8: feature pairs per vector (≥1).
- FEATURE_WIDTH, 16: signed feature width.
- FEATURE_FRAC, 8: fractional bits of features.
- ACC_WIDTH, 40: unsigned distance accumulator width.
- GAMMA_WIDTH, 16: unsigned gamma width.
- GAMMA_FRAC, 12: fractional bits of gamma.
- X_INT, 8: integer bits of x, sign included (matches the exponential input integer width).
- X_FRAC, 8: fractional bits of x. Constraint: 2*FEATURE_FRAC+GAMMA_FRAC ≥ X_FRAC.
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- clear  in  1  synchronous abort of the current vector.
- in_valid  in  1  feature pair present.
- in_ready  out  1  block accepts a pair this cycle.
- feature_a  in  FEATURE_WIDTH  signed support-vector feature.
- feature_b  in  FEATURE_WIDTH  signed sample feature.
- gamma  in  GAMMA_WIDTH  unsigned kernel gamma; sampled in SCALE.
- x  out  X_INT+X_FRAC  signed result -gamma·‖a-b‖²; always ≤ 0.
- data_valid  out  1  one-cycle pulse when x is new.

## Operation
- A pair transfers on a posedge with in_valid & in_ready. in_ready = (state == ACCUM) and is combinational from state.
- FSM states: ACCUM, DRAIN, SCALE, EMIT. Reset state is ACCUM.
  - ACCUM: each transfer registers diff = a-b (FEATURE_WIDTH+1 bits, signed, exact) and sets diff_valid. It also increments cnt (0..FEATURE_COUNT-1). The transfer with cnt == FEATURE_COUNT-1 sets cnt←0 and moves to DRAIN.
  - Every cycle with diff_valid set: acc ← acc + diff² (square unsigned, 2·FEATURE_WIDTH+1 bits). acc saturates at 2^ACC_WIDTH-1 and never wraps. diff_valid clears unless a new transfer occurs on the same edge.
  - DRAIN: the final square is added → SCALE.
  - SCALE: prod ← acc·gamma (ACC_WIDTH+GAMMA_WIDTH bits, unsigned) → EMIT.
  - EMIT:
    - mag = prod >> (2·FEATURE_FRAC+GAMMA_FRAC-X_FRAC), truncating.
    - x ← -min(mag, 2^(X_INT+X_FRAC-1)), so the most negative value is reached on saturation.
    - data_valid ← 1; acc ← 0; → ACCUM.
- data_valid is 0 on every other cycle. x holds its value between results.
- clear (reset inactive) forces on the next edge: state ACCUM, cnt 0, acc 0, diff_valid 0, data_valid 0; x unchanged. It overrides any transfer on the same edge, and that pair is dropped. A clear in EMIT suppresses the pulse.
- Asynchronous reset: x=0, data_valid=0, state ACCUM (in_ready=1), cnt=0, acc=0, diff_valid=0, prod=0. It may assert in any state; no pulse results from an interrupted vector.

## Timing
- Let edge T accept the last pair. Then: DRAIN after T, SCALE after T+1, EMIT after T+2. x/data_valid update at edge T+3 and are visible for the cycle after it.
- Latency is 3 cycles from last-pair acceptance to data_valid.
- in_ready is low for exactly 3 cycles after T; the next pair can transfer at edge T+4 earliest.
- Throughput with in_valid held high: FEATURE_COUNT+3 cycles per result.
- Gaps in in_valid during ACCUM are allowed at any point; cnt and acc hold.
- FEATURE_COUNT=1: the first transfer goes straight to DRAIN.
- gamma only needs to be stable on the SCALE edge.

## Test plan
- Basic result: defaults, FEATURE_COUNT=4, a=(1.0,2.0,0,0) (0x0100,0x0200,0,0), b=0, gamma=0.5 (0x0800) → one data_valid pulse, x=0xFD80 (-2.5), exactly 3 cycles after the 4th transfer.
- Equal vectors: a=b=(0x1234,-0x0500,0x7FFF,0x8000), gamma=0xFFFF → x=0x0000 with data_valid pulse.
- Saturation: a=0x7FFF, b=0x8000 on all pairs, gamma=0xFFFF → x=0x8000. Also drive acc past its max with narrow ACC_WIDTH=20 → acc holds all-ones, no wrap.
- Handshake and gaps:
  - Hold in_valid high for 3 vectors → in_ready low exactly 3 cycles after each final transfer; pulses spaced 7 cycles.
  - Random in_valid gaps → identical x values.
- clear mid-vector:
  - Clear after 2 transfers, then a full vector → only one pulse, value of the new vector.
  - Clear on the same edge as a transfer → that pair is dropped.
  - Clear in EMIT → no pulse.
- Async reset:
  - Assert reset mid-edge-less in SCALE → x=0, data_valid=0, in_ready=1 immediately.
  - After release, the next vector produces the correct result with no stale pulse.
